// File: rtl/rot_cmd_sequencer.sv
// rtl/rot_cmd_sequencer.sv - command FIFO and multi-pass sequencer in front of a combinational 8-bit rotator
module rot_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_lr,
    input  logic [2:0]                 cmd_amount,
    input  logic [1:0]                 cmd_reps,
    input  logic [W-1:0]               cmd_data,
    output logic                       rot_lr,
    output logic [2:0]                 rot_amount,
    output logic [W-1:0]               rot_data,
    input  logic [W-1:0]               rot_result,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [W-1:0]               res_data,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = W + 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic              push;
    logic              pop;
    logic [EW-1:0]     head;

    logic              work_lr;
    logic [2:0]        work_amount;
    logic [W-1:0]      work_data;
    logic [1:0]        rep_cnt;

    // Handshake qualifiers: a pop only happens from IDLE, so a full FIFO never sees a same-cycle refill.
    always_comb begin
        cmd_ready = (count != CW'(DEPTH));
        push      = cmd_valid && cmd_ready;
        pop       = (state == IDLE) && (count != '0);
        head      = mem[rd_ptr];
    end

    // Command storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_lr, cmd_amount, cmd_reps, cmd_data};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: IDLE loads a command, RUN counts passes, DONE waits for the consumer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (rep_cnt == 2'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Working registers and result holding; each RUN cycle feeds the rotator output back as the next operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_lr     <= 1'b0;
            work_amount <= 3'd0;
            work_data   <= '0;
            rep_cnt     <= 2'd0;
            res_data    <= '0;
            res_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        work_lr     <= head[EW-1];
                        work_amount <= head[EW-2:EW-4];
                        rep_cnt     <= head[W+1:W];
                        work_data   <= head[W-1:0];
                    end
                end
                RUN: begin
                    work_data <= rot_result;
                    if (rep_cnt == 2'd0) begin
                        res_data  <= rot_result;
                        res_valid <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt - 2'd1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

    // Rotator inputs come straight from registers so no cmd_* path reaches rot_*.
    always_comb begin
        rot_lr     = work_lr;
        rot_amount = work_amount;
        rot_data   = work_data;
        fifo_count = count;
        busy       = (state != IDLE) || (count != '0);
    end

endmodule

// File: tb/tb_rot_cmd_sequencer.sv
// tb/tb_rot_cmd_sequencer.sv - self-checking bench for rot_cmd_sequencer with a rotator model and result scoreboard
module tb_rot_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int W     = 8;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_lr;
    logic [2:0]   cmd_amount;
    logic [1:0]   cmd_reps;
    logic [W-1:0] cmd_data;
    logic         rot_lr;
    logic [2:0]   rot_amount;
    logic [W-1:0] rot_data;
    logic [W-1:0] rot_result;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         busy;
    logic [2:0]   fifo_count;

    int errors = 0;
    int checks = 0;
    int n_results = 0;
    logic [W-1:0] exp_q[$];
    logic         hold_prev = 1'b0;
    logic [W-1:0] prev_data = '0;

    rot_cmd_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_lr     (cmd_lr),
        .cmd_amount (cmd_amount),
        .cmd_reps   (cmd_reps),
        .cmd_data   (cmd_data),
        .rot_lr     (rot_lr),
        .rot_amount (rot_amount),
        .rot_data   (rot_data),
        .rot_result (rot_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational rotator.
    function automatic logic [W-1:0] rotator(input logic lr, input logic [2:0] a, input logic [W-1:0] d);
        logic [W-1:0] r;
        if (lr) r = (d << a) | (d >> (4'd8 - {1'b0, a}));
        else    r = (d >> a) | (d << (4'd8 - {1'b0, a}));
        return r;
    endfunction

    assign rot_result = rotator(rot_lr, rot_amount, rot_data);

    // Net effect of a whole command: one rotation by amount*(reps+1) mod 8.
    function automatic logic [W-1:0] net_model(input logic lr, input logic [2:0] a,
                                               input logic [1:0] reps, input logic [W-1:0] d);
        int n;
        logic [15:0] t;
        n = (int'(a) * (int'(reps) + 1)) % 8;
        t = {d, d};
        if (lr) begin
            t = t << n;
            return t[15:8];
        end else begin
            t = t >> n;
            return t[7:0];
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected results queued at push, compared at handshake; also hold and ready rules.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 32'(res_valid), 32'd1);
                check("hold_data", 32'(res_data), 32'(prev_data));
            end
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back(net_model(cmd_lr, cmd_amount, cmd_reps, cmd_data));
            end
            if (res_valid && res_ready) begin
                check("result_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("result_data", 32'(res_data), 32'(exp_q.pop_front()));
                end
                n_results++;
            end
            check("cmd_ready_rule", 32'(cmd_ready), 32'(fifo_count != 3'(DEPTH)));
            hold_prev = res_valid && !res_ready;
            prev_data = res_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic lr, input logic [2:0] a, input logic [1:0] reps, input logic [W-1:0] d);
        int t;
        t = 0;
        cmd_lr = lr; cmd_amount = a; cmd_reps = reps; cmd_data = d; cmd_valid = 1'b1;
        while (!cmd_ready && t < 200) begin
            step();
            t++;
        end
        check("send_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 500) begin
            step();
            t++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_results(input int n);
        int t;
        t = 0;
        while (n_results < n && t < 500) begin
            step();
            t++;
        end
        check("drain_timeout", 32'(n_results >= n), 32'd1);
    endtask

    initial begin
        int accepted;
        int n0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_lr = 1'b0; cmd_amount = 3'd0;
        cmd_reps = 2'd0; cmd_data = '0; res_ready = 1'b0;

        // Model pinned against hand-computed values.
        check("model_r1", 32'(net_model(1'b0, 3'd1, 2'd0, 8'h96)), 32'h4B);
        check("model_l3", 32'(net_model(1'b1, 3'd3, 2'd0, 8'h96)), 32'hB4);
        check("model_r3x3", 32'(net_model(1'b0, 3'd3, 2'd2, 8'h96)), 32'h4B);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step();
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rot", {22'd0, rot_lr, rot_amount, rot_data}, 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);

        // Single right rotate by 1.
        res_ready = 1'b1;
        send(1'b0, 3'd1, 2'd0, 8'h96);
        step();
        check("t1_rot_data", 32'(rot_data), 32'h96);
        check("t1_rot_amount", 32'(rot_amount), 32'd1);
        check("t1_rot_lr", 32'(rot_lr), 32'd0);
        check("t1_early_valid", 32'(res_valid), 32'd0);
        step();
        check("t1_valid", 32'(res_valid), 32'd1);
        check("t1_data", 32'(res_data), 32'h4B);
        step();
        check("t1_one_wide", 32'(res_valid), 32'd0);

        // Left 3, then right 3 over three passes.
        send(1'b1, 3'd3, 2'd0, 8'h96);
        step();
        step();
        check("t2a_valid", 32'(res_valid), 32'd1);
        check("t2a_data", 32'(res_data), 32'hB4);
        step();
        send(1'b0, 3'd3, 2'd2, 8'h96);
        step(); step(); step();
        check("t2b_early_valid", 32'(res_valid), 32'd0);
        step();
        check("t2b_valid", 32'(res_valid), 32'd1);
        check("t2b_data", 32'(res_data), 32'h4B);
        wait_idle();

        // Backpressure: six offered, five held.
        res_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            cmd_lr = 1'(i); cmd_amount = 3'(i + 1); cmd_reps = 2'(i);
            cmd_data = 8'h11 * 8'(i + 1) ^ 8'h5A;
            cmd_valid = 1'b1;
            if (i == 5) begin
                check("full_ready", 32'(cmd_ready), 32'd0);
                check("full_count", 32'(fifo_count), 32'd4);
            end
            if (cmd_ready) accepted++;
            step();
        end
        cmd_valid = 1'b0;
        check("bp_accepted", 32'(accepted), 32'd5);
        n0 = n_results;
        res_ready = 1'b1;
        wait_results(n0 + 5);
        wait_idle();

        // amount=0 with three extra passes returns data unchanged.
        send(1'b1, 3'd0, 2'd3, 8'hA5);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("t4_busy", 32'(busy), 32'd1);
            if (k < 5) check("t4_early_valid", 32'(res_valid), 32'd0);
        end
        check("t4_valid", 32'(res_valid), 32'd1);
        check("t4_data", 32'(res_data), 32'hA5);
        step();
        check("t4_busy_after", 32'(busy), 32'd0);
        check("t4_valid_after", 32'(res_valid), 32'd0);

        // Asynchronous reset while running with two queued commands.
        res_ready = 1'b0;
        send(1'b1, 3'd2, 2'd3, 8'h3C);
        send(1'b0, 3'd5, 2'd1, 8'hE1);
        send(1'b1, 3'd7, 2'd0, 8'h0F);
        check("t5_pre_count", 32'(fifo_count), 32'd2);
        check("t5_pre_amount", 32'(rot_amount), 32'd2);
        rst_n = 1'b0;
        #1;
        check("t5_valid", 32'(res_valid), 32'd0);
        check("t5_count", 32'(fifo_count), 32'd0);
        check("t5_rot", {22'd0, rot_lr, rot_amount, rot_data}, 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        res_ready = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("t5_no_stale", 32'(res_valid), 32'd0);
        end
        step();

        // Push and handshake together with FIFO at DEPTH-1.
        res_ready = 1'b0;
        n0 = n_results;
        send(1'b0, 3'd2, 2'd0, 8'hC7);
        send(1'b1, 3'd1, 2'd1, 8'h81);
        send(1'b0, 3'd6, 2'd2, 8'h3A);
        send(1'b1, 3'd5, 2'd3, 8'hD2);
        check("t6_pre_count", 32'(fifo_count), 32'd3);
        check("t6_pre_valid", 32'(res_valid), 32'd1);
        cmd_lr = 1'b0; cmd_amount = 3'd4; cmd_reps = 2'd1; cmd_data = 8'h69; cmd_valid = 1'b1;
        res_ready = 1'b1;
        check("t6_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        check("t6_count", 32'(fifo_count), 32'd4);
        check("t6_valid_cleared", 32'(res_valid), 32'd0);
        check("t6_full_ready", 32'(cmd_ready), 32'd0);
        wait_results(n0 + 5);
        wait_idle();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rot_cmd_sequencer.md
Name: rot_cmd_sequencer

Overview:
- Command-issue stage that sits directly upstream of the combinational 8-bit bidirectional rotator.
- Buffers rotate commands in a small FIFO and drives the rotator's lr/amount/data inputs from working registers.
- Optionally feeds the rotator result back for repeated passes, then holds the final result in a registered valid/ready output.
- The rotator itself stays purely combinational; this block adds all sequencing, buffering and flow control.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- W, 8, data width; fixed to match the rotator, no other value is supported.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO can accept
- cmd_lr  in  1  1 = rotate left, 0 = rotate right
- cmd_amount  in  3  rotate distance per pass
- cmd_reps  in  2  extra passes; total passes = cmd_reps+1
- cmd_data  in  W  operand
- rot_lr  out  1  to rotator lr
- rot_amount  out  3  to rotator amount
- rot_data  out  W  to rotator data_in
- rot_result  in  W  from rotator data_out (combinational return)
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  W  final rotated value
- busy  out  1  FSM not in IDLE, or FIFO not empty
- fifo_count  out  clog2(DEPTH)+1  entries in FIFO

Behaviour:
- Reset (async, rst_n=0): FIFO emptied, fifo_count=0, FSM=IDLE. Working regs, rot_lr/rot_amount/rot_data, res_data and res_valid all cleared to 0. cmd_ready=1 once reset releases; busy=0.
- Push: on the edge with cmd_valid&&cmd_ready, write {lr,amount,reps,data} to the FIFO.
- cmd_ready = (fifo_count!=DEPTH). A push is refused when full even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: fifo_count unchanged, both operations take effect.
- rot_lr, rot_amount and rot_data are driven directly from the working registers. No combinational path exists from cmd_* to rot_*.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - FIFO non-empty -> pop the head entry into the working regs, set rep_cnt=reps, go to RUN.
  - FIFO empty -> stay in IDLE; working regs hold their values.
- RUN, each cycle:
  - work_data <= rot_result.
  - If rep_cnt==0: res_data <= rot_result, res_valid <= 1, go to DONE.
  - Else rep_cnt <= rep_cnt-1 and stay in RUN.
  - lr and amount hold for every pass.
- DONE: res_valid and res_data hold stable until res_valid&&res_ready. On that edge res_valid <= 0 and the FSM goes to IDLE. No pop occurs in DONE.
- Latency: for a command accepted into an empty, idle block at edge T, res_valid is high after edge T+2+reps.
- Throughput: one command per reps+3 cycles when res_ready is held high.
- Arithmetic: the net result equals rotation by (amount*(reps+1)) mod W in the cmd_lr direction. amount=0 returns the data unchanged after the same latency.
- Capacity: DEPTH commands in the FIFO plus one in RUN/DONE.
- Backpressure: if res_ready stays low, the FIFO fills and cmd_ready drops; no command is lost or reordered.
- Ordering: results are strictly in command order.
- Reset mid-operation: any state aborts immediately. In-flight and queued commands are discarded and res_valid goes low asynchronously.
- Hold values: cmd_* are ignored when cmd_ready=0. res_data is don't-care-stable (held) when res_valid=0.

Test Plan:
- Reset, then cmd 0x96, lr=0, amount=1, reps=0, res_ready=1 -> rot_data=0x96, rot_amount=1 during RUN; res_valid high after the 2nd edge after accept, res_data=0x4B, one cycle wide.
- cmd 0x96, lr=1, amount=3, reps=0 -> res_data=0xB4; then lr=0, amount=3, reps=2 (net right 1) -> res_data=0x4B, res_valid high 4 edges after accept.
- res_ready=0, push 6 commands back-to-back -> 5 accepted, cmd_ready low from the 6th, fifo_count=4. Release res_ready -> 5 results in push order, each correct.
- amount=0, reps=3, data 0xA5 (either lr) -> res_data=0xA5 after 5 edges; busy high throughout, low after the handshake with FIFO empty.
- Assert rst_n=0 while in RUN with 2 queued commands -> res_valid=0, fifo_count=0, rot_* = 0 immediately, with no clock edge needed. After release, no stale result appears.
- Push and handshake in the same cycle with FIFO at DEPTH-1 -> count increments correctly, no overflow, subsequent results correct.
